// File: rtl/spi_response_tx.sv
// spi_response_tx: MISO serializer for an SD-style SPI slave.
// Response bytes are queued in a small FIFO and shifted out MSB first,
// byte-aligned to the CS-low frame. 0xFF filler bytes are inserted to meet
// the command-to-response gap, and 0x00 bytes are sent while busy_hold is high.
module spi_response_tx #(
    parameter int DEPTH     = 8,
    parameter int NCR_BYTES = 1
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     CS,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     flush,
    input  logic                     busy_hold,
    output logic                     DO,
    output logic                     fifo_full,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    output logic                     byte_done,
    output logic                     tx_active
);
    localparam int              AW     = $clog2(DEPTH);
    localparam int              LW     = AW + 1;
    localparam logic [3:0]      NCR_L  = 4'(NCR_BYTES);
    localparam logic [LW-1:0]   FULL_L = LW'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_q, bit_d;
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0] level_q, level_d;
    logic [3:0]    gap_q, gap_d;
    logic          in_burst_q, in_burst_d;
    logic          tx_q, tx_d;
    logic          done_q, done_d;
    logic          ovf_q, ovf_d;
    logic          boundary, full, pop, push;

    // Pop/push decisions, all taken from pre-edge state
    always_comb begin
        boundary = !CS && (bit_q == 3'd0);
        full     = (level_q == FULL_L);
        pop      = boundary && !busy_hold && (level_q != '0) &&
                   (in_burst_q || (gap_q >= NCR_L));
        push     = wr_en && !flush && (!full || pop);
    end

    // Next-state for the shifter, burst/gap tracking and FIFO bookkeeping
    always_comb begin
        shift_d    = shift_q;
        bit_d      = bit_q;
        in_burst_d = in_burst_q;
        gap_d      = gap_q;
        tx_d       = tx_q;
        ovf_d      = ovf_q;
        // A FIFO byte is complete only when the counter is back at a boundary;
        // this covers both a normal boundary and CS rising right after the
        // last bit. A mid-byte CS rise sees bit_q != 0 and reports nothing.
        done_d     = tx_q && (bit_q == 3'd0);

        if (CS) begin
            shift_d    = 8'hFF;
            bit_d      = 3'd0;
            in_burst_d = 1'b0;
            gap_d      = 4'd0;
            tx_d       = 1'b0;
        end else begin
            bit_d = bit_q + 3'd1;
            if (bit_q != 3'd0) begin
                shift_d = {shift_q[6:0], 1'b1};
            end else if (busy_hold) begin
                shift_d    = 8'h00;
                in_burst_d = 1'b0;
                tx_d       = 1'b0;
            end else if (pop) begin
                shift_d    = mem_q[rd_q];
                in_burst_d = 1'b1;
                gap_d      = 4'd0;
                tx_d       = 1'b1;
            end else begin
                shift_d    = 8'hFF;
                in_burst_d = 1'b0;
                tx_d       = 1'b0;
                if (gap_q < 4'd8) gap_d = gap_q + 4'd1;
            end
        end

        rd_d    = rd_q + AW'(pop);
        wr_d    = wr_q + AW'(push);
        level_d = level_q + LW'(push) - LW'(pop);
        if (wr_en && !flush && full && !pop) ovf_d = 1'b1;

        // Flush clears the queue but leaves whatever was just loaded alone
        if (flush) begin
            rd_d       = '0;
            wr_d       = '0;
            level_d    = '0;
            ovf_d      = 1'b0;
            in_burst_d = 1'b0;
        end
    end

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge CLK) begin
        if (push) mem_q[wr_q] <= wr_data;
    end

    // State registers with asynchronous reset
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            shift_q    <= 8'hFF;
            bit_q      <= 3'd0;
            rd_q       <= '0;
            wr_q       <= '0;
            level_q    <= '0;
            gap_q      <= 4'd0;
            in_burst_q <= 1'b0;
            tx_q       <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            bit_q      <= bit_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            level_q    <= level_d;
            gap_q      <= gap_d;
            in_burst_q <= in_burst_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
        end
    end

    assign DO         = shift_q[7];
    assign fifo_full  = (level_q == FULL_L);
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
    assign byte_done  = done_q;
    assign tx_active  = tx_q;

endmodule

// File: tb/tb_spi_response_tx.sv
// Bench for spi_response_tx: a hand-built vector table for the first frame,
// directed sequences for bursts, busy, overflow/flush, CS abort and async
// reset, then random traffic against a byte-queue reference model.
module tb_spi_response_tx;
    localparam int DEPTH = 8;
    localparam int NCR   = 1;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          CLK = 1'b0;
    logic          reset, CS, wr_en, flush, busy_hold;
    logic [7:0]    wr_data;
    logic          DO, fifo_full, overflow, byte_done, tx_active;
    logic [LW-1:0] fifo_level;

    spi_response_tx #(.DEPTH(DEPTH), .NCR_BYTES(NCR)) dut (
        .CLK(CLK), .reset(reset), .CS(CS), .wr_en(wr_en), .wr_data(wr_data),
        .flush(flush), .busy_hold(busy_hold), .DO(DO), .fifo_full(fifo_full),
        .fifo_level(fifo_level), .overflow(overflow), .byte_done(byte_done),
        .tx_active(tx_active)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the FIFO is a queue, the wire holds one whole byte and
    // m_pos says which bit of it is currently on DO (7 = last bit / idle).
    logic [7:0] fq[$];
    logic [7:0] m_cur;
    int         m_pos, m_gap;
    bit         m_ovf, m_done, m_ff, m_burst;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        m_cur = 8'hFF; m_pos = 7; m_gap = 0;
        m_ovf = 0; m_done = 0; m_ff = 0; m_burst = 0;
    endtask

    task automatic model_step(input bit cs, input bit wr, input logic [7:0] wd,
                              input bit fl, input bit busy);
        bit popped   = 0;
        bit full_pre = (fq.size() == DEPTH);
        if (cs) begin
            m_done  = m_ff && (m_pos == 7);
            m_cur   = 8'hFF; m_pos = 7; m_ff = 0; m_burst = 0; m_gap = 0;
        end else if (m_pos == 7) begin
            m_done = m_ff;
            m_pos  = 0;
            if (busy) begin
                m_cur = 8'h00; m_burst = 0; m_ff = 0;
            end else if (fq.size() > 0 && (m_burst || m_gap >= NCR)) begin
                m_cur = fq.pop_front(); popped = 1; m_burst = 1; m_gap = 0; m_ff = 1;
            end else begin
                m_cur = 8'hFF; m_burst = 0; m_ff = 0;
                if (m_gap < 8) m_gap++;
            end
        end else begin
            m_done = 0;
            m_pos++;
        end
        if (fl) begin
            fq.delete(); m_ovf = 0; m_burst = 0;
        end else if (wr) begin
            if (full_pre && !popped) m_ovf = 1;
            else fq.push_back(wd);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {23'd0, DO, fifo_full, fifo_level, overflow, byte_done, tx_active};
    endfunction

    function automatic logic [31:0] model_outs();
        logic [LW-1:0] lvl = LW'(fq.size());
        return {23'd0, m_cur[7 - m_pos], (fq.size() == DEPTH), lvl, m_ovf, m_done, m_ff};
    endfunction

    // One clock: drive while CLK is low, step the model at the edge, compare
    // on the falling edge.
    task automatic cycle(input bit cs, input bit wr, input logic [7:0] wd,
                         input bit fl, input bit busy);
        CS = cs; wr_en = wr; wr_data = wd; flush = fl; busy_hold = busy;
        @(posedge CLK);
        model_step(cs, wr, wd, fl, busy);
        @(negedge CLK);
        chk("outs {DO,full,level,ovf,done,tx}", dut_outs(), model_outs());
    endtask

    task automatic idle(input bit cs);
        cycle(cs, 0, 8'h00, 0, 0);
    endtask

    typedef struct {
        bit         cs, wr;
        logic [7:0] wd;
        bit         e_do, e_tx, e_done;
        int         e_lvl;
    } vec_t;

    function automatic vec_t mk(bit cs, bit wr, logic [7:0] wd, bit d, bit tx, bit dn, int lvl);
        vec_t v;
        v.cs = cs; v.wr = wr; v.wd = wd; v.e_do = d; v.e_tx = tx; v.e_done = dn; v.e_lvl = lvl;
        return v;
    endfunction

    vec_t        tbl[$];
    logic [23:0] got;
    int          dn;
    bit          rcs, rbusy;

    initial begin
        // First frame, NCR=1: one filler byte, then 0x01, then filler again
        tbl.push_back(mk(0, 1, 8'h01, 1, 0, 0, 1));
        for (int k = 1; k < 8; k++) tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 1));
        tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
        for (int k = 9; k < 15; k++) tbl.push_back(mk(0, 0, 8'h00, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 8'h00, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'h00, 1, 0, 0, 0));

        reset = 1; CS = 1; wr_en = 0; wr_data = 0; flush = 0; busy_hold = 0;
        model_reset();
        #2;
        chk("reset outs", dut_outs(), {23'd0, 1'b1, 1'b0, LW'(0), 1'b0, 1'b0, 1'b0});
        @(negedge CLK);
        reset = 0;

        foreach (tbl[i]) begin
            cycle(tbl[i].cs, tbl[i].wr, tbl[i].wd, 0, 0);
            chk($sformatf("table[%0d] {DO,tx,done,level}", i),
                {tx_active, DO, byte_done, 28'(fifo_level)},
                {tbl[i].e_tx, tbl[i].e_do, tbl[i].e_done, 28'(tbl[i].e_lvl)});
        end

        // Three queued bytes go out back to back once the gap is met
        cycle(0, 1, 8'h00, 0, 0);
        cycle(0, 1, 8'hAB, 0, 0);
        cycle(0, 1, 8'hCD, 0, 0);
        repeat (5) idle(0);
        got = '0; dn = 0;
        for (int k = 0; k < 24; k++) begin
            idle(0);
            got = {got[22:0], DO};
            dn += int'(byte_done);
            if (k % 8 == 0) chk($sformatf("burst level at byte %0d", k / 8),
                                32'(fifo_level), 32'(2 - k / 8));
            if (k == 8 || k == 16) chk("burst done pulse", 32'(byte_done), 32'd1);
        end
        chk("burst bits", 32'(got), 32'h0000ABCD);
        idle(0);
        dn += int'(byte_done);
        chk("burst done count", dn, 3);

        // Busy bytes take precedence over queued data and keep the gap
        cycle(0, 1, 8'h05, 0, 0);
        repeat (6) idle(0);
        got = '0;
        for (int k = 0; k < 24; k++) begin
            cycle(0, 0, 8'h00, 0, 1);
            got = {got[22:0], DO};
            if (tx_active) chk("tx during busy", 32'(tx_active), 32'd0);
        end
        chk("busy bits", 32'(got), 32'd0);
        got = '0;
        for (int k = 0; k < 8; k++) begin
            idle(0);
            got = {got[22:0], DO};
        end
        chk("byte after busy", 32'(got[7:0]), 32'h05);

        // Overflow with CS high, then flush
        CS = 1;
        for (int k = 0; k <= DEPTH; k++) cycle(1, 1, 8'(8'h60 + k), 0, 0);
        chk("full after overfill", {fifo_full, overflow, 30'(fifo_level)},
            {1'b1, 1'b1, 30'(DEPTH)});
        cycle(1, 0, 8'h00, 1, 0);
        chk("after flush", {fifo_full, overflow, 30'(fifo_level)}, 32'd0);

        // CS rises 3 bits into 0xA5: aborted, never resent
        cycle(1, 1, 8'hA5, 0, 0);
        cycle(1, 1, 8'h3C, 0, 0);
        cycle(1, 1, 8'h00, 0, 0);
        repeat (8) idle(0);
        got = '0;
        for (int k = 0; k < 3; k++) begin
            idle(0);
            got = {got[22:0], DO};
        end
        chk("A5 first 3 bits", 32'(got), 32'h5);
        idle(1);
        chk("abort {DO,done}", {DO, byte_done}, 2'b10);
        idle(1);
        chk("abort no late done", 32'(byte_done), 32'd0);
        repeat (8) idle(0);
        got = '0;
        for (int k = 0; k < 8; k++) begin
            idle(0);
            got = {got[22:0], DO};
        end
        chk("byte after abort", 32'(got[7:0]), 32'h3C);

        // Async reset mid-byte (0x00 currently on the wire)
        idle(0);
        idle(0);
        chk("DO low before reset", 32'(DO), 32'd0);
        #2 reset = 1;
        #1;
        chk("async reset outs", dut_outs(), {23'd0, 1'b1, 1'b0, LW'(0), 1'b0, 1'b0, 1'b0});
        model_reset();
        @(negedge CLK);
        reset = 0;
        idle(1);
        chk("level after reset", 32'(fifo_level), 32'd0);

        // Random traffic against the model
        rcs = 0; rbusy = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(29) == 0) rcs = ~rcs;
            if ($urandom_range(39) == 0) rbusy = ~rbusy;
            cycle(rcs, ($urandom_range(3) == 0), 8'($urandom),
                  ($urandom_range(199) == 0), rbusy);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
